// File: rtl/toycpu_pkg.sv
// Shared definitions for the toy CPU: opcodes, control state encoding and
// instruction field positions (also used by the ALU op decoder).
package toycpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_JMP  = 4'd2;
  localparam logic [3:0] OP_JZ   = 4'd3;
  localparam logic [3:0] OP_JC   = 4'd4;
  localparam logic [3:0] OP_HALT = 4'd14;
  localparam logic [3:0] OP_MV   = 4'd15;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  function automatic logic [3:0] ir_op(input logic [15:0] ir);
    return ir[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/toycpu_control.sv
// Multi-cycle fetch/decode/execute controller sitting in front of the ALU
// and register file; fetches over a req/ack instruction-memory port.
module toycpu_control
  import toycpu_pkg::*;
#(
  parameter int             PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [3:0]      alu_op,
  output logic            alu_sel_imm,
  output logic [15:0]     imm,
  output logic [3:0]      rf_ra1,
  output logic [3:0]      rf_ra2,
  output logic [3:0]      rf_wa,
  output logic            rf_we,
  input  logic            cFlag,
  input  logic            zFlag,
  output logic            halted
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      op;
  logic            jump_taken;
  logic            exec;

  assign op = ir_op(ir_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    jump_taken = (op == OP_JMP) || (op == OP_JZ && zFlag) || (op == OP_JC && cFlag);
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (jump_taken) begin
          pc_d    = ir_q[PC_W-1:0];
          state_d = ST_FETCH;
        end else if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (op == OP_ADD || op == OP_MV || op == OP_LDI) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC:  state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
    endcase
  end

  // alu_op stays MV outside an ADD execute cycle so the ALU flags only move on ADD.
  always_comb begin
    exec        = (state_q == ST_EXEC);
    imem_req    = (state_q == ST_FETCH) && !rst;
    imem_addr   = pc_q;
    alu_op      = (exec && op == OP_ADD) ? OP_ADD : OP_MV;
    alu_sel_imm = exec && (op == OP_LDI);
    imm         = exec ? {8'h00, ir_q[IMM_MSB:IMM_LSB]} : 16'h0000;
    rf_ra1      = exec ? ir_q[RS_MSB:RS_LSB] : 4'h0;
    rf_ra2      = exec ? ir_q[RT_MSB:RT_LSB] : 4'h0;
    rf_wa       = exec ? ir_q[RD_MSB:RD_LSB] : 4'h0;
    rf_we       = exec;
    halted      = (state_q == ST_HALT);
  end

endmodule
